// File: rtl/issue_ctrl_pkg.sv
// Shared CPU definitions for the issue stage: functional-unit indices,
// issue FSM encoding and the exception code used for undecodable instructions.
package issue_ctrl_pkg;

    localparam int unsigned NUM_FU    = 5;
    localparam int unsigned FU_ALU    = 0;
    localparam int unsigned FU_MDU    = 1;
    localparam int unsigned FU_BRANCH = 2;
    localparam int unsigned FU_LSU    = 3;
    localparam int unsigned FU_CSR    = 4;

    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned REG_AW    = 5;

    // One-hot select of the csr unit; every serializing instruction goes there.
    localparam logic [NUM_FU-1:0] UNIT_CSR_OH = 5'b10000;

    // Exception code attached to an instruction that selects no unit at all.
    localparam logic [4:0] EXC_ILLEGAL = 5'd4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HELD  = 2'd1,
        ST_DRAIN = 2'd2
    } iss_state_e;

    // Serializing instructions wait for the whole machine to go idle.
    function automatic logic is_serializing(input logic [6:0] futype,
                                            input logic [4:0] exc);
        return (exc != 5'd0) || futype[FU_CSR] || (futype == 7'd0);
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Register busy tracking for the issue stage: one set port (the issuing
// instruction's destination), NWB clear ports (writebacks), and the RAW/WAW
// hazard check for the held instruction against the registered busy vector.
module issue_scoreboard
    import issue_ctrl_pkg::*;
#(
    parameter int NWB = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  set_en_i,
    input  logic [REG_AW-1:0]     set_addr_i,
    input  logic [NWB-1:0]        wb_valid_i,
    input  logic [REG_AW*NWB-1:0] wb_addr_i,
    input  logic [REG_AW-1:0]     rs1_i,
    input  logic                  rs1_en_i,
    input  logic [REG_AW-1:0]     rs2_i,
    input  logic                  rs2_en_i,
    input  logic [REG_AW-1:0]     rd_i,
    input  logic                  rd_en_i,
    output logic                  hazard_o,
    output logic                  empty_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Next busy vector: clears first so a same-cycle set of the same bit wins.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NWB; i++) begin
            if (wb_valid_i[i]) begin
                busy_d[wb_addr_i[i*REG_AW +: REG_AW]] = 1'b0;
            end
        end
        if (set_en_i && (set_addr_i != '0)) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Hazard uses only registered state; a writeback this cycle does not bypass.
    always_comb begin
        hazard_o = (rs1_en_i && busy_q[rs1_i])
                 | (rs2_en_i && busy_q[rs2_i])
                 | (rd_en_i  && busy_q[rd_i]);
    end

    assign empty_o = (busy_q == '0);

endmodule

// File: rtl/issue_ctrl.sv
// Single-entry issue stage: accepts one decoded instruction, holds it until
// its operands are free (or the machine is idle, for serializing ones), and
// presents it one-hot to the selected functional unit.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_EMPTY | no instruction held, ready to accept
//  ST_HELD  | normal instruction held, issues when hazard-free
//  ST_DRAIN | serializing instruction held, issues to csr when busy == 0
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int NWB = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            in_futype,
    input  logic [5:0]            in_uop,
    input  logic [31:0]           in_imm,
    input  logic [31:0]           in_pc,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [4:0]            in_rd,
    input  logic                  in_rs1_en,
    input  logic                  in_rs2_en,
    input  logic                  in_rd_en,
    input  logic [4:0]            in_exc,
    output logic [NUM_FU-1:0]     iss_valid,
    input  logic [NUM_FU-1:0]     fu_ready,
    output logic [5:0]            iss_uop,
    output logic [31:0]           iss_imm,
    output logic [31:0]           iss_pc,
    output logic [4:0]            iss_rs1,
    output logic [4:0]            iss_rs2,
    output logic [4:0]            iss_rd,
    output logic                  iss_rd_en,
    output logic [4:0]            iss_exc,
    input  logic [NWB-1:0]        wb_valid,
    input  logic [REG_AW*NWB-1:0] wb_addr,
    input  logic                  flush,
    output logic                  sb_empty,
    output logic [31:0]           stall_cnt
);

    iss_state_e        state_q;
    logic [NUM_FU-1:0] unit_q;
    logic [5:0]        uop_q;
    logic [31:0]       imm_q;
    logic [31:0]       pc_q;
    logic [4:0]        rs1_q;
    logic [4:0]        rs2_q;
    logic [4:0]        rd_q;
    logic              rs1_en_q;
    logic              rs2_en_q;
    logic              rd_en_q;
    logic [4:0]        exc_q;
    logic [31:0]       stall_q;
    logic [31:0]       stall_d;

    logic              hazard;
    logic              take;
    logic              capture;
    logic              serializing;
    logic              blocked;

    issue_scoreboard #(
        .NWB (NWB)
    ) u_scoreboard (
        .clk        (clk),
        .resetn     (resetn),
        .set_en_i   (take && rd_en_q),
        .set_addr_i (rd_q),
        .wb_valid_i (wb_valid),
        .wb_addr_i  (wb_addr),
        .rs1_i      (rs1_q),
        .rs1_en_i   (rs1_en_q),
        .rs2_i      (rs2_q),
        .rs2_en_i   (rs2_en_q),
        .rd_i       (rd_q),
        .rd_en_i    (rd_en_q),
        .hazard_o   (hazard),
        .empty_o    (sb_empty)
    );

    // Issue request: a HELD instruction offers itself regardless of fu_ready.
    always_comb begin
        iss_valid = '0;
        case (state_q)
            ST_HELD:  iss_valid = hazard ? '0 : unit_q;
            ST_DRAIN: iss_valid = sb_empty ? UNIT_CSR_OH : '0;
            default:  iss_valid = '0;
        endcase
    end

    assign take        = ((iss_valid & fu_ready) != '0) && !flush;
    assign in_ready    = !flush && ((state_q == ST_EMPTY) || take);
    assign capture     = in_valid && in_ready;
    assign serializing = is_serializing(in_futype, in_exc);
    assign blocked     = ((state_q == ST_HELD) && hazard)
                       || ((state_q == ST_DRAIN) && !sb_empty);

    // Issue FSM and held payload.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_EMPTY;
            unit_q   <= '0;
            uop_q    <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            rs1_en_q <= 1'b0;
            rs2_en_q <= 1'b0;
            rd_en_q  <= 1'b0;
            exc_q    <= '0;
        end else if (flush) begin
            state_q <= ST_EMPTY;
        end else if (capture) begin
            state_q  <= serializing ? ST_DRAIN : ST_HELD;
            unit_q   <= serializing ? UNIT_CSR_OH : in_futype[NUM_FU-1:0];
            uop_q    <= in_uop;
            imm_q    <= in_imm;
            pc_q     <= in_pc;
            rs1_q    <= in_rs1;
            rs2_q    <= in_rs2;
            rd_q     <= in_rd;
            rs1_en_q <= in_rs1_en;
            rs2_en_q <= in_rs2_en;
            rd_en_q  <= in_rd_en;
            exc_q    <= ((in_futype == 7'd0) && (in_exc == 5'd0)) ? EXC_ILLEGAL : in_exc;
        end else if (take) begin
            state_q <= ST_EMPTY;
        end
    end

    assign stall_d = blocked ? (stall_q + 32'd1) : stall_q;

    // Count cycles lost to operand hazards and serialization drain.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
    assign iss_uop   = uop_q;
    assign iss_imm   = imm_q;
    assign iss_pc    = pc_q;
    assign iss_rs1   = rs1_q;
    assign iss_rs2   = rs2_q;
    assign iss_rd    = rd_q;
    assign iss_rd_en = rd_en_q;
    assign iss_exc   = exc_q;

endmodule
